uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- Debug/loader bridge that turns a byte command stream from the UART receive path into word transactions on the SoC's valid/ready memory bus.
- Acts as a bus initiator (the counterpart of the SoC's memory responders), so a host can peek/poke BRAM, SDRAM and IO over serial.
- Replies (ACK/NAK/read data) go back out through the UART transmit path.
- Sits beside the CPU behind a bus arbiter (arbiter not part of this block).

Parameters:
- RX_TIMEOUT, 32'd1_000_000: idle clk cycles allowed between bytes of one command before the partial command is discarded.
- BUS_TIMEOUT, 16'd4096: clk cycles mem_valid may stay high without mem_ready before the access is aborted.
- ACK_BYTE, 8'h06: response byte for a completed write.
- NAK_BYTE, 8'h15: response byte for a bad opcode or a bus timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte
- rx_data  in  8  received byte
- tx_valid  out  1  tx_data valid toward the UART transmitter
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter idle; a byte is accepted on a cycle with tx_valid && tx_ready
- mem_valid  out  1  bus request
- mem_ready  in  1  one-cycle responder completion
- mem_addr  out  32  word address; bits [1:0] forced to 0
- mem_wstrb  out  4  4'hF for writes, 4'h0 for reads
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid on the mem_ready cycle
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (resetn is synchronous, active-low; clock is clk):
  - All outputs are 0 and the state is IDLE.
  - Reset mid-command or mid-bus-access drops mem_valid/tx_valid on the next edge and discards all partial state.
- Command format (all multi-byte fields MSB first):
  - 'W' (8'h57) + addr[31:0] + data[31:0] (9 bytes) -> reply ACK_BYTE.
  - 'R' (8'h52) + addr[31:0] (5 bytes) -> reply rdata[31:24], [23:16], [15:8], [7:0].
  - Any other opcode byte in IDLE -> reply NAK_BYTE, then return to IDLE. No further bytes are consumed for it.
- States: IDLE, ADDR, DATA, BUS, RESP, GAP.
  - IDLE: on rx_valid, latch the opcode. 'W'/'R' go to ADDR with byte_cnt=0; anything else loads NAK and goes to RESP.
  - ADDR: each rx_valid shifts a byte into addr. After the 4th byte, 'W' goes to DATA and 'R' goes to BUS.
  - DATA: each rx_valid shifts a byte into wdata. After the 4th byte, go to BUS.
  - BUS: mem_valid asserts on the cycle after entry and holds until mem_ready is sampled high. It deasserts on the next edge.
    - Read: latch mem_rdata on the ready cycle and load 4 response bytes.
    - Write: load ACK.
    - Then go to RESP.
  - RESP: tx_valid=1 with the current byte. On tx_valid && tx_ready, go to GAP.
  - GAP: one cycle with tx_valid=0, so the transmitter's ready can fall. Return to RESP if bytes remain, else to IDLE.
- Handshake rules:
  - mem_addr, mem_wstrb and mem_wdata are stable for the whole time mem_valid is high.
  - At most one outstanding access.
  - mem_ready while mem_valid=0 is ignored.
- rx_valid outside IDLE/ADDR/DATA (i.e. in BUS/RESP/GAP) is dropped. No buffering.
- RX timeout:
  - A counter clears on every rx_valid and on entry to ADDR.
  - If it reaches RX_TIMEOUT in ADDR or DATA, return to IDLE silently with no reply.
  - Counter width is 32 bits and it saturates; no wrap.
- Bus timeout:
  - The counter runs while mem_valid=1.
  - On reaching BUS_TIMEOUT, deassert mem_valid, reply NAK_BYTE (1 byte, also for reads), and ignore any late mem_ready.
  - If mem_ready and timeout land on the same cycle, mem_ready wins and the normal response is sent.
- Latency:
  - Last command byte to mem_valid: 2 cycles.
  - mem_ready to first tx_valid: 1 cycle.
- Response order: for a read, the 4 bytes go out strictly MSB first, each separated by at least one GAP cycle.

Test Plan:
- Write: rx 57 00 00 10 00 DE AD BE EF; responder gives ready after 3 cycles -> one mem_valid pulse-train with addr=0x00001000, wstrb=F, wdata=0xDEADBEEF; tx sends 06.
- Read: rx 52 80 00 00 04; mem_rdata=0x12345678 with ready -> wstrb=0, addr=0x80000004; tx sends 12 34 56 78 in order, each gated by tx_ready, with tx_valid low for ≥1 cycle between bytes.
- Bad opcode: rx 41 -> no mem_valid; tx sends 15; the next 'R' command is processed normally.
- Stall: rx 57 00 00, then silence for RX_TIMEOUT cycles -> busy drops, no tx, no mem_valid; a following full write completes with 06.
- Bus timeout: read to an address whose responder never readies -> mem_valid drops after BUS_TIMEOUT cycles, tx sends 15. A late ready in the same cycle as timeout -> normal data reply.
- Reset mid-BUS and mid-RESP -> mem_valid=0, tx_valid=0 and busy=0 after the reset edge; no residual bytes sent after release.

Source files
------------

// File: rtl/uart_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_master
// Purpose  : Debug/loader bridge. Turns a serial byte command stream into
//            single-word accesses on the SoC valid/ready memory bus and sends
//            ACK/NAK/read-data bytes back to the UART transmitter.
//            Commands (multi-byte fields MSB first):
//              'W' addr[31:0] data[31:0] -> ACK_BYTE
//              'R' addr[31:0]            -> rdata[31:24] .. rdata[7:0]
//              other opcode              -> NAK_BYTE
// Ports    : clk, resetn            clock, synchronous active-low reset
//            rx_valid, rx_data      received-byte strobe and byte
//            tx_valid, tx_data,
//            tx_ready               outgoing byte handshake
//            mem_valid, mem_ready,
//            mem_addr, mem_wstrb,
//            mem_wdata, mem_rdata   initiator side of the memory bus
//            busy                   high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_bus_master #(
  parameter logic [31:0] RX_TIMEOUT  = 32'd1_000_000,
  parameter logic [15:0] BUS_TIMEOUT = 16'd4096,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [7:0] C_OP_WRITE = 8'h57;
  localparam logic [7:0] C_OP_READ  = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_is_write;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_mem_valid;
  logic        r_issued;     // request already launched for this BUS visit
  logic [15:0] r_bus_cnt;
  logic [31:0] r_rx_cnt;
  logic [31:0] r_resp;       // outgoing bytes, current byte in [31:24]
  logic [2:0]  r_resp_left;

  logic        w_is_cmd;
  logic        w_last_byte;
  logic        w_rx_to;
  logic        w_bus_hit;
  logic        w_bus_to;

  assign w_is_cmd    = (rx_data == C_OP_WRITE) || (rx_data == C_OP_READ);
  assign w_last_byte = rx_valid && (r_byte_cnt == 2'd3);
  // A byte arriving on the expiry cycle keeps the command alive.
  assign w_rx_to     = (r_rx_cnt >= RX_TIMEOUT) && !rx_valid;
  assign w_bus_hit   = r_mem_valid && mem_ready;
  // Fires on the last allowed cycle of mem_valid; mem_ready on that same
  // cycle takes precedence through w_bus_hit.
  assign w_bus_to    = r_mem_valid && !mem_ready &&
                       (r_bus_cnt == BUS_TIMEOUT - 16'd1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and FSM-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    tx_valid     = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          w_state_next = w_is_cmd ? S_ADDR : S_RESP;
        end
      end
      S_ADDR: begin
        if (w_last_byte) begin
          w_state_next = r_is_write ? S_DATA : S_BUS;
        end else if (w_rx_to) begin
          w_state_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_last_byte) begin
          w_state_next = S_BUS;
        end else if (w_rx_to) begin
          w_state_next = S_IDLE;
        end
      end
      S_BUS: begin
        if (w_bus_hit || w_bus_to) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        w_state_next = (r_resp_left != 3'd0) ? S_RESP : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_is_write  <= 1'b0;
      r_byte_cnt  <= 2'd0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_mem_valid <= 1'b0;
      r_issued    <= 1'b0;
      r_bus_cnt   <= 16'h0;
      r_rx_cnt    <= 32'h0;
      r_resp      <= 32'h0;
      r_resp_left <= 3'd0;
    end else begin
      // Inter-byte idle counter, saturating.
      if (rx_valid) begin
        r_rx_cnt <= 32'h0;
      end else if (r_rx_cnt != 32'hFFFF_FFFF) begin
        r_rx_cnt <= r_rx_cnt + 32'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_issued   <= 1'b0;
          r_byte_cnt <= 2'd0;
          if (rx_valid) begin
            r_is_write <= (rx_data == C_OP_WRITE);
            if (!w_is_cmd) begin
              r_resp      <= {NAK_BYTE, 24'h0};
              r_resp_left <= 3'd1;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_addr     <= {r_addr[23:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_wdata    <= {r_wdata[23:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_BUS: begin
          if (!r_issued) begin
            r_mem_valid <= 1'b1;
            r_issued    <= 1'b1;
            r_bus_cnt   <= 16'h0;
          end else if (w_bus_hit) begin
            r_mem_valid <= 1'b0;
            if (r_is_write) begin
              r_resp      <= {ACK_BYTE, 24'h0};
              r_resp_left <= 3'd1;
            end else begin
              r_resp      <= mem_rdata;
              r_resp_left <= 3'd4;
            end
          end else if (w_bus_to) begin
            r_mem_valid <= 1'b0;
            r_resp      <= {NAK_BYTE, 24'h0};
            r_resp_left <= 3'd1;
          end else begin
            r_bus_cnt <= r_bus_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (tx_ready) begin
            r_resp      <= {r_resp[23:0], 8'h00};
            r_resp_left <= r_resp_left - 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tx_data   = tx_valid ? r_resp[31:24] : 8'h00;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_addr & 32'hFFFF_FFFC;
  assign mem_wstrb = (r_mem_valid && r_is_write) ? 4'hF : 4'h0;
  assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_bus_master
// Purpose  : Directed self-checking bench for uart_bus_master. Short
//            timeout parameters keep the stall and bus-timeout cases brief.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_bus_master;

  localparam logic [31:0] RX_TO  = 32'd200;
  localparam logic [15:0] BUS_TO = 16'd50;
  localparam logic [7:0]  ACK    = 8'h06;
  localparam logic [7:0]  NAK    = 8'h15;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_bus_master #(
    .RX_TIMEOUT (RX_TO),
    .BUS_TIMEOUT(BUS_TO),
    .ACK_BYTE   (ACK),
    .NAK_BYTE   (NAK)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All stimulus and sampling happens 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input bit with_data);
    send_byte(op);
    for (int i = 0; i < 4; i++) begin
      send_byte(addr[31:24]);
      addr = addr << 8;
    end
    if (with_data) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(data[31:24]);
        data = data << 8;
      end
    end
  endtask

  // Acts as the memory responder right after the last command byte.
  task automatic bus_respond(input string name, input logic [31:0] exp_addr,
                             input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                             input bit chk_wdata, input int delay,
                             input logic [31:0] rdata, input bit inject_rx);
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_lat_early: mem_valid got %b expected 0", name, mem_valid);
    end
    step();
    n_checks++;
    if (mem_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_lat_valid: mem_valid got %b expected 1", name, mem_valid);
    end
    n_checks++;
    if (mem_addr !== exp_addr || mem_wstrb !== exp_wstrb) begin
      n_fail++;
      $display("FAIL %s_addr: addr/wstrb got %h/%h expected %h/%h",
               name, mem_addr, mem_wstrb, exp_addr, exp_wstrb);
    end
    if (chk_wdata) begin
      n_checks++;
      if (mem_wdata !== exp_wdata) begin
        n_fail++;
        $display("FAIL %s_wdata: got %h expected %h", name, mem_wdata, exp_wdata);
      end
    end
    for (int i = 0; i < delay; i++) begin
      if (inject_rx && i == 0) begin
        rx_data  = 8'h41;
        rx_valid = 1'b1;
      end
      step();
      rx_valid = 1'b0;
      n_checks++;
      if (mem_valid !== 1'b1 || mem_addr !== exp_addr || mem_wstrb !== exp_wstrb) begin
        n_fail++;
        $display("FAIL %s_hold: valid/addr/wstrb got %b/%h/%h expected 1/%h/%h",
                 name, mem_valid, mem_addr, mem_wstrb, exp_addr, exp_wstrb);
      end
    end
    mem_rdata = rdata;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    mem_rdata = 32'hA5A5_A5A5;
    n_checks++;
    if (mem_valid !== 1'b0 || tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: mem_valid/tx_valid got %b/%b expected 0/1",
               name, mem_valid, tx_valid);
    end
  endtask

  // Accepts n response bytes, holding tx_ready low for 'hold' cycles on each.
  task automatic collect(input string name, input logic [31:0] exp,
                         input int n, input int hold);
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (tx_valid !== 1'b1 && w < 20) begin
        step();
        w++;
      end
      n_checks++;
      if (tx_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_tx_wait%0d: tx_valid got %b expected 1", name, k, tx_valid);
      end
      n_checks++;
      if (tx_data !== exp[31:24]) begin
        n_fail++;
        $display("FAIL %s_byte%0d: tx_data got %h expected %h", name, k, tx_data, exp[31:24]);
      end
      for (int h = 0; h < hold; h++) begin
        step();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp[31:24]) begin
          n_fail++;
          $display("FAIL %s_stall%0d: valid/data got %b/%h expected 1/%h",
                   name, k, tx_valid, tx_data, exp[31:24]);
        end
      end
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      n_checks++;
      if (tx_valid !== 1'b0 || mem_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_gap%0d: tx_valid/mem_valid got %b/%b expected 0/0",
                 name, k, tx_valid, mem_valid);
      end
      exp = exp << 8;
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: busy/tx_valid got %b/%b expected 0/0", name, busy, tx_valid);
    end
  endtask

  // Watches several cycles for any unexpected activity.
  task automatic expect_quiet(input string name, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (tx_valid !== 1'b0 || mem_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL %s_quiet: activity got 1 expected 0", name);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    n_checks++;
    if ({tx_valid, tx_data, mem_valid, mem_addr, mem_wstrb, mem_wdata, busy} !== 79'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {tx_valid, tx_data, mem_valid, mem_addr, mem_wstrb, mem_wdata, busy});
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_write();
    send_cmd(8'h57, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
    bus_respond("write", 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 1'b1, 3, 32'h0, 1'b1);
    collect("write", {ACK, 24'h0}, 1, 0);
    expect_quiet("write_drop_rx", 5);
  endtask

  task automatic test_read();
    send_cmd(8'h52, 32'h8000_0004, 32'h0, 1'b0);
    bus_respond("read", 32'h8000_0004, 4'h0, 32'h0, 1'b0, 1, 32'h1234_5678, 1'b0);
    collect("read", 32'h1234_5678, 4, 2);
  endtask

  task automatic test_bad_opcode();
    send_byte(8'h41);
    n_checks++;
    if (busy !== 1'b1 || mem_valid !== 1'b0 || tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL badop_state: busy/mem_valid/tx_valid got %b/%b/%b expected 1/0/1",
               busy, mem_valid, tx_valid);
    end
    collect("badop", {NAK, 24'h0}, 1, 0);
    send_cmd(8'h52, 32'h0000_0020, 32'h0, 1'b0);
    bus_respond("badop_read", 32'h0000_0020, 4'h0, 32'h0, 1'b0, 0, 32'hCAFE_F00D, 1'b0);
    collect("badop_read", 32'hCAFE_F00D, 4, 0);
  endtask

  task automatic test_stall();
    bit seen = 1'b0;
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    for (int i = 0; i < int'(RX_TO) - 5; i++) begin
      step();
      if (tx_valid !== 1'b0 || mem_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_early: busy got %b expected 1", busy);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_valid !== 1'b0 || mem_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (busy !== 1'b0 || seen) begin
      n_fail++;
      $display("FAIL stall_drop: busy/activity got %b/%b expected 0/0", busy, seen);
    end
    // Unaligned address: low bits must be forced to zero on the bus.
    send_cmd(8'h57, 32'h0000_2003, 32'h0BAD_F00D, 1'b1);
    bus_respond("stall_write", 32'h0000_2000, 4'hF, 32'h0BAD_F00D, 1'b1, 0, 32'h0, 1'b0);
    collect("stall_write", {ACK, 24'h0}, 1, 0);
  endtask

  task automatic test_bus_timeout();
    int cnt = 0;
    send_cmd(8'h52, 32'h0000_0100, 32'h0, 1'b0);
    step();
    while (mem_valid === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
    n_checks++;
    if (cnt != int'(BUS_TO)) begin
      n_fail++;
      $display("FAIL bus_to_len: mem_valid cycles got %0d expected %0d", cnt, BUS_TO);
    end
    // Late ready after abort must be ignored.
    mem_rdata = 32'h1111_2222;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    collect("bus_to", {NAK, 24'h0}, 1, 0);

    // Ready on the very cycle the timeout would fire: normal reply.
    send_cmd(8'h52, 32'h0000_0104, 32'h0, 1'b0);
    step();
    for (int i = 1; i < int'(BUS_TO); i++) step();
    n_checks++;
    if (mem_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bus_to_edge_valid: mem_valid got %b expected 1", mem_valid);
    end
    mem_rdata = 32'h89AB_CDEF;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    n_checks++;
    if (mem_valid !== 1'b0 || tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bus_to_edge_done: mem_valid/tx_valid got %b/%b expected 0/1",
               mem_valid, tx_valid);
    end
    collect("bus_to_edge", 32'h89AB_CDEF, 4, 0);
  endtask

  task automatic test_reset_mid();
    // Mid-BUS
    send_cmd(8'h52, 32'h0000_0200, 32'h0, 1'b0);
    step();
    step();
    resetn = 1'b0;
    step();
    n_checks++;
    if ({mem_valid, tx_valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_bus: valid/tx/busy got %b expected 000", {mem_valid, tx_valid, busy});
    end
    resetn    = 1'b1;
    tx_ready  = 1'b1;
    mem_ready = 1'b1;
    expect_quiet("reset_bus", 6);
    mem_ready = 1'b0;
    tx_ready  = 1'b0;

    // Mid-RESP
    send_cmd(8'h52, 32'h0000_0204, 32'h0, 1'b0);
    bus_respond("reset_resp", 32'h0000_0204, 4'h0, 32'h0, 1'b0, 0, 32'h5566_7788, 1'b0);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    step();
    resetn = 1'b0;
    step();
    n_checks++;
    if ({mem_valid, tx_valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_resp: valid/tx/busy got %b expected 000", {mem_valid, tx_valid, busy});
    end
    resetn   = 1'b1;
    tx_ready = 1'b1;
    expect_quiet("reset_resp", 8);
    tx_ready = 1'b0;

    // Still functional afterwards.
    send_cmd(8'h57, 32'h0000_0300, 32'h0102_0304, 1'b1);
    bus_respond("reset_after", 32'h0000_0300, 4'hF, 32'h0102_0304, 1'b1, 1, 32'h0, 1'b0);
    collect("reset_after", {ACK, 24'h0}, 1, 0);
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_stall();
    test_bus_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
